// File: rtl/uart_rx_byte_if.sv
// Serial receive bus for uart_rx_byte: line in, byte and status pulses out.
// The master drives rx_line; the receiver (slave) drives everything else.
interface uart_rx_byte_if;
    logic       rx_line;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy_flag;
    logic       frame_error;
    logic       parity_error;

    modport master (
        output rx_line,
        input  data_out,
        input  data_valid,
        input  busy_flag,
        input  frame_error,
        input  parity_error
    );

    modport slave (
        input  rx_line,
        output data_out,
        output data_valid,
        output busy_flag,
        output frame_error,
        output parity_error
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with centre sampling and frame-error detection.
// Define UART_RX_PARITY_EN for an even-parity bit after the data bits.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int HALF_BIT     = 5208
) (
    input  logic          clk_100MHZ,
    input  logic          rst_n,
    uart_rx_byte_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t BIT_END  = cnt_t'(CLKS_PER_BIT - 1);
    localparam cnt_t HALF_END = cnt_t'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] dout_q, dout_d;
    logic       dv_q, dv_d;
    logic       fe_q, fe_d;
    logic [1:0] sync_q;
    logic       rx_s;
    logic       bit_end;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       pe_q, pe_d;
    logic       par_bad;
`endif

    // Sync flops reset high so release never looks like a start edge
    always_ff @(posedge clk_100MHZ or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], bus.rx_line};
    end

    assign rx_s    = sync_q[1];
    assign bit_end = (cnt_q == BIT_END);
`ifdef UART_RX_PARITY_EN
    assign par_bad = ^{sh_q, par_q};
`endif

    always_ff @(posedge clk_100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            pe_q    <= pe_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pe_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    if (idx_q != 4'd8) idx_d = idx_q + 4'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 4'd7) state_d = PARITY;
`else
                    if (idx_q == 4'd7) state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            pe_d = 1'b1;
                        end else begin
                            dout_d = sh_q;
                            dv_d   = 1'b1;
                        end
`else
                        dout_d = sh_q;
                        dv_d   = 1'b1;
`endif
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                        pe_d    = par_bad;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_out    = dout_q;
    assign bus.data_valid  = dv_q;
    assign bus.frame_error = fe_q;
    assign bus.busy_flag   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error = pe_q;
`else
    assign bus.parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte with a byte scoreboard.
// Short bit times keep frames to a few hundred cycles.
module tb_uart_rx_byte;
    localparam int CPB = 16;
    localparam int HB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif
    localparam int LAT = 2 + HB + (NB - 1) * CPB;

    logic clk_100MHZ = 1'b0;
    logic rst_n      = 1'b0;

    uart_rx_byte_if bus();

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT    (HB)
    ) dut (
        .clk_100MHZ(clk_100MHZ),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk_100MHZ = ~clk_100MHZ;

    int n_cmp     = 0;
    int n_bad     = 0;
    int fe_cnt    = 0;
    int pe_cnt    = 0;
    int valid_cnt = 0;
    int cyc       = 0;
    int fall_cyc  = 0;
    int valid_cyc = 0;
    int vc0       = 0;
    logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    always @(posedge clk_100MHZ) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every data_valid cycle pops one expected byte
    always @(negedge clk_100MHZ) begin
        if (rst_n) begin
            if (bus.data_valid) begin
                logic [8:0] e;
                valid_cnt++;
                valid_cyc = cyc;
                e = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()}
                                        : 9'h1FF;
                check("rx_byte", {23'd0, 1'b0, bus.data_out}, {23'd0, e});
            end
            if (bus.frame_error)  fe_cnt++;
            if (bus.parity_error) pe_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_100MHZ);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v);
        bus.rx_line = 1'b0;
        fall_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx_line = b[i];
            tick(CPB);
            if (i == 3) check("busy_mid", {31'd0, bus.busy_flag}, 1);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx_line = (^b) ^ par_flip;
        tick(CPB);
`endif
        bus.rx_line = stop_v;
        tick(CPB);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 4 * NB * CPB) begin
            tick(1);
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int d;
        logic [7:0] ab;
        bus.rx_line = 1'b1;
        rst_n = 1'b0;
        tick(5);
        check("rst_dout",  {24'd0, bus.data_out}, 0);
        check("rst_dv",    {31'd0, bus.data_valid}, 0);
        check("rst_busy",  {31'd0, bus.busy_flag}, 0);
        check("rst_fe",    {31'd0, bus.frame_error}, 0);
        check("rst_pe",    {31'd0, bus.parity_error}, 0);
        rst_n = 1'b1;
        tick(5);
        check("post_rst_busy", {31'd0, bus.busy_flag}, 0);

        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        wait_drain();
        check("a5_dout", {24'd0, bus.data_out}, 32'hA5);
        check("a5_busy_end", {31'd0, bus.busy_flag}, 0);
        d = valid_cyc - fall_cyc;
        check("latency", {31'd0, (d >= LAT - 1 && d <= LAT + 1)}, 1);

        vc0 = valid_cnt;
        bus.rx_line = 1'b0;
        tick(HB / 2);
        bus.rx_line = 1'b1;
        tick(3 * CPB);
        check("glitch_busy", {31'd0, bus.busy_flag}, 0);
        check("glitch_fe", fe_cnt, 0);
        check("glitch_nvalid", valid_cnt, vc0);

        send(8'h3C, 1'b0);
        tick(CPB);
        check("break_busy", {31'd0, bus.busy_flag}, 1);
        check("fe_once", fe_cnt, 1);
        check("fe_dout", {24'd0, bus.data_out}, 32'hA5);
        bus.rx_line = 1'b1;
        tick(6);
        check("break_idle", {31'd0, bus.busy_flag}, 0);
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1);
        wait_drain();
        check("dout_55", {24'd0, bus.data_out}, 32'h55);

        vc0 = valid_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        wait_drain();
        check("b2b_count", valid_cnt, vc0 + 2);
        check("b2b_dout", {24'd0, bus.data_out}, 32'hFF);

        vc0 = valid_cnt;
        ab = 8'h5A;
        bus.rx_line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx_line = ab[i];
            tick(CPB);
        end
        bus.rx_line = ab[4];
        tick(CPB / 2);
        rst_n = 1'b0;
        tick(3);
        check("midrst_busy", {31'd0, bus.busy_flag}, 0);
        check("midrst_dout", {24'd0, bus.data_out}, 0);
        bus.rx_line = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3 * CPB);
        check("midrst_nvalid", valid_cnt, vc0);
        check("midrst_idle", {31'd0, bus.busy_flag}, 0);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1);
        wait_drain();
        check("dout_81", {24'd0, bus.data_out}, 32'h81);

`ifdef UART_RX_PARITY_EN
        vc0 = valid_cnt;
        par_flip = 1'b1;
        send(8'h07, 1'b1);
        tick(CPB);
        check("par_err", pe_cnt, 1);
        check("par_nvalid", valid_cnt, vc0);
        par_flip = 1'b0;
        exp_q.push_back(8'h07);
        send(8'h07, 1'b1);
        wait_drain();
        check("dout_07", {24'd0, bus.data_out}, 32'h07);
`else
        check("pe_never", pe_cnt, 0);
`endif
        check("fe_total", fe_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
